write_back: RTL

- Final pipeline stage. Consumes the execute stage's registered outputs (instr_out, rd_data, csrd_data) and retires the instruction.
- Owns the 32x32 general-purpose register file and the machine CSR file, including the 64-bit cycle and instret counters.
- Provides combinational, write-bypassed read ports to the decode/register-read stage, which produces rs1_data, rs2_data and csr_data for execute.

---
 rtl/write_back.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/write_back.sv
// Retirement stage: owns the general-purpose register file and the machine CSR
// file (including the 64-bit cycle/instret counters), and serves write-bypassed
// combinational read ports to the register-read stage.

package write_back_pkg;
    typedef struct packed {
        logic [4:0]  rd;
        logic        writes_rd;
        logic        is_csr;
        logic [11:0] csr_addr;
    } instr_t;
endpackage

module write_back
    import write_back_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            enabled,
    input  instr_t          instr,
    input  logic [XLEN-1:0] rd_data,
    input  logic [XLEN-1:0] csrd_data,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [11:0]     csr_raddr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] csr_rdata,
    output logic            retired
);

    localparam int CW = 2 * XLEN;

    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;

    logic [XLEN-1:0] gpr [NREG];

    logic [XLEN-1:0] mscratch, mtvec, mepc, mcause;
    logic [CW-1:0]   mcycle, minstret;

    logic            gpr_we, csr_we;
    logic            wr_scratch, wr_tvec, wr_epc, wr_cause;
    logic            wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;
    logic [XLEN-1:0] csr_wval;

    // "view" = the CSR state with this cycle's write applied but no counter
    // increment; it serves both the read bypass and the written next state.
    logic [XLEN-1:0] scratch_view, tvec_view, epc_view, cause_view;
    logic [CW-1:0]   mcycle_view, minstret_view;
    logic [CW-1:0]   mcycle_nxt, minstret_nxt;

    // Qualify this cycle's GPR/CSR writes and apply the CSR write mask.
    always_comb begin
        gpr_we     = rstn && enabled && instr.writes_rd && (instr.rd != 5'd0);
        csr_we     = rstn && enabled && instr.is_csr;
        wr_scratch = csr_we && (instr.csr_addr == A_MSCRATCH);
        wr_tvec    = csr_we && (instr.csr_addr == A_MTVEC);
        wr_epc     = csr_we && (instr.csr_addr == A_MEPC);
        wr_cause   = csr_we && (instr.csr_addr == A_MCAUSE);
        wr_cyc_lo  = csr_we && (instr.csr_addr == A_MCYCLE);
        wr_cyc_hi  = csr_we && (instr.csr_addr == A_MCYCLEH);
        wr_ins_lo  = csr_we && (instr.csr_addr == A_MINSTRET);
        wr_ins_hi  = csr_we && (instr.csr_addr == A_MINSTRETH);
        csr_wval   = csrd_data;
        if (wr_tvec || wr_epc) begin
            csr_wval[1:0] = 2'b00;
        end
    end

    // Build the post-write CSR view and the counters' next values.
    always_comb begin
        scratch_view  = wr_scratch ? csr_wval : mscratch;
        tvec_view     = wr_tvec    ? csr_wval : mtvec;
        epc_view      = wr_epc     ? csr_wval : mepc;
        cause_view    = wr_cause   ? csr_wval : mcause;
        mcycle_view   = mcycle;
        minstret_view = minstret;
        if (wr_cyc_lo) mcycle_view[XLEN-1:0]    = csr_wval;
        if (wr_cyc_hi) mcycle_view[CW-1:XLEN]   = csr_wval;
        if (wr_ins_lo) minstret_view[XLEN-1:0]  = csr_wval;
        if (wr_ins_hi) minstret_view[CW-1:XLEN] = csr_wval;
        mcycle_nxt    = (wr_cyc_lo || wr_cyc_hi) ? mcycle_view : mcycle + CW'(1);
        if (wr_ins_lo || wr_ins_hi) begin
            minstret_nxt = minstret_view;
        end else if (enabled) begin
            minstret_nxt = minstret + CW'(1);
        end else begin
            minstret_nxt = minstret;
        end
    end

    // One storage register per GPR; x0 is never written, so it stays zero.
    for (genvar g = 0; g < NREG; g++) begin : g_gpr
        // Clear on reset, otherwise capture rd_data when this entry is the target.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                gpr[g] <= '0;
            end else if (gpr_we && (instr.rd == 5'(g))) begin
                gpr[g] <= rd_data;
            end
        end
    end

    // CSR file, counters and the retirement pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mscratch <= '0;
            mtvec    <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mcycle   <= '0;
            minstret <= '0;
            retired  <= 1'b0;
        end else begin
            mscratch <= scratch_view;
            mtvec    <= tvec_view;
            mepc     <= epc_view;
            mcause   <= cause_view;
            mcycle   <= mcycle_nxt;
            minstret <= minstret_nxt;
            retired  <= enabled;
        end
    end

    // GPR read ports: x0 reads zero, a same-cycle write to the index wins.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rstn) begin
            if (rs1_addr != 5'd0) begin
                rs1_data = (gpr_we && (instr.rd == rs1_addr)) ? rd_data : gpr[rs1_addr];
            end
            if (rs2_addr != 5'd0) begin
                rs2_data = (gpr_we && (instr.rd == rs2_addr)) ? rd_data : gpr[rs2_addr];
            end
        end
    end

    // CSR read port from the post-write view; read-only aliases mirror the counters.
    always_comb begin
        csr_rdata = '0;
        if (rstn) begin
            case (csr_raddr)
                A_MSCRATCH:              csr_rdata = scratch_view;
                A_MTVEC:                 csr_rdata = tvec_view;
                A_MEPC:                  csr_rdata = epc_view;
                A_MCAUSE:                csr_rdata = cause_view;
                A_MCYCLE,   A_CYCLE:     csr_rdata = mcycle_view[XLEN-1:0];
                A_MCYCLEH,  A_CYCLEH:    csr_rdata = mcycle_view[CW-1:XLEN];
                A_MINSTRET, A_INSTRET:   csr_rdata = minstret_view[XLEN-1:0];
                A_MINSTRETH, A_INSTRETH: csr_rdata = minstret_view[CW-1:XLEN];
                default:                 csr_rdata = '0;
            endcase
        end
    end

endmodule
